// File: rtl/sum_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package sum_pkg;

  localparam int DEF_BIN_W  = 11;
  localparam int DEF_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam logic [BCD_W-1:0] ADD3_TH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Combinational double-dabble correction cell: digits of five or more get +3 before the shift.
module bcd_add3
  import sum_pkg::*;
(
  input  logic [BCD_W-1:0] in_i,
  output logic [BCD_W-1:0] out_o
);

  always_comb begin
    if (in_i >= ADD3_TH) begin
      out_o = in_i + 4'd3;
    end else begin
      out_o = in_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock behind a start/busy/done handshake.
// Optional macro LEADING_ZERO_BLANK_EN registers a leading-zero blanking mask alongside bcd_out.
module bin_to_bcd_seq
  import sum_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      overflow,
  output logic [DIGITS-1:0]         blank
);

  localparam int                BCD_TW   = BCD_W * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  bcd_state_t          state_q;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [BCD_TW-1:0]   bcd_q, adj_d, bcd_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q, ovf_d;
  logic                busy_q, done_q, overflow_q;
  logic [BCD_TW-1:0]   bcd_out_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (bcd_q[g*BCD_W +: BCD_W]),
      .out_o (adj_d[g*BCD_W +: BCD_W])
    );
  end

  // Bit leaving the top digit means the value no longer fits; it is folded into a sticky flag.
  assign bcd_d   = {adj_d[BCD_TW-2:0], shift_q[BIN_W-1]};
  assign shift_d = {shift_q[BIN_W-2:0], 1'b0};
  assign ovf_d   = ovf_q | adj_d[BCD_TW-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= bin_in;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          bcd_q   <= bcd_d;
          ovf_q   <= ovf_d;
          cnt_q   <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            bcd_out_q  <= bcd_d;
            overflow_q <= ovf_d;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zrun_s;

  // A digit is blanked only when it and every digit above it are zero; the units digit always shows.
  always_comb begin
    blank_d = '0;
    zrun_s  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun_s     = zrun_s & (bcd_d[i*BCD_W +: BCD_W] == 4'd0);
      blank_d[i] = zrun_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= '0;
    end else if (state_q == SHIFT && cnt_q == CNT_ONE) begin
      blank_q <= blank_d;
    end else begin
      blank_q <= blank_q;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default 4-digit build plus a 3-digit instance).
module tb_bin_to_bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start, start3;
  logic [10:0] bin_in, bin3;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;

  int n_total = 0;
  int n_bad   = 0;

  bin_to_bcd_seq #(.BIN_W(11), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow), .blank(blank)
  );

  bin_to_bcd_seq #(.BIN_W(11), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3), .blank(blank3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from = edges already elapsed counting the capture edge as 1
  task automatic wait_done(input int from, output int edges);
    edges = from;
    while (done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_conv(input string tag, input logic [10:0] val,
                          input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
    int n;
    bin_in = val;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check_val({tag, "_busy_rise"}, busy, 1);
    wait_done(1, n);
    check_val({tag, "_latency"}, n, 12);
    check_val({tag, "_bcd"}, bcd_out, exp_bcd);
    check_val({tag, "_ovf"}, overflow, 0);
    check_val({tag, "_blank"}, blank, BLK_EN ? exp_blank : 4'b0000);
    check_val({tag, "_busy_done"}, busy, 1);
    tick();
    check_val({tag, "_done_fall"}, {busy, done}, 2'b00);
    check_val({tag, "_hold"}, bcd_out, exp_bcd);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b0; start = 1'b0; bin_in = '0; start3 = 1'b0; bin3 = '0;
    repeat (3) tick();
    check_val("rst_state", {busy, done, overflow, bcd_out, blank}, 0);
    rst = 1'b1;

    pulses = 0;
    repeat (5) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check_val("idle_no_done", pulses, 0);

    run_conv("v2016", 11'd2016, 16'h2016, 4'b0000);
    run_conv("v7",    11'd7,    16'h0007, 4'b1110);
    run_conv("v0",    11'd0,    16'h0000, 4'b1110);
    run_conv("v105",  11'd105,  16'h0105, 4'b1000);

    // back-to-back with start held high throughout
    bin_in = 11'd0;
    start  = 1'b1;
    tick();
    bin_in = 11'd2047;
    wait_done(1, n);
    check_val("b2b_lat0", n, 12);
    check_val("b2b_bcd0", bcd_out, 16'h0000);
    tick();
    check_val("b2b_idle", busy, 0);
    tick();
    check_val("b2b_accept", busy, 1);
    start = 1'b0;
    wait_done(1, n);
    check_val("b2b_lat1", n, 12);
    check_val("b2b_bcd1", bcd_out, 16'h2047);
    tick();

    // start re-pulsed with a new value during SHIFT must be ignored
    bin_in = 11'd1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    start  = 1'b1;
    bin_in = 11'd5;
    repeat (2) tick();
    start  = 1'b0;
    wait_done(6, n);
    check_val("ign_latency", n, 12);
    check_val("ign_bcd", bcd_out, 16'h1234);
    pulses = 0;
    repeat (15) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check_val("ign_single_done", pulses, 0);
    check_val("ign_not_busy", busy, 0);

    // three-digit instance: overflow wraps modulo 1000
    bin3   = 11'd1275;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 1;
    while (done3 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("d3_latency", n, 12);
    check_val("d3_bcd_ovf", bcd3, 12'h275);
    check_val("d3_ovf_set", ovf3, 1);
    check_val("d3_blank_ovf", blank3, 3'b000);
    tick();
    bin3   = 11'd99;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 1;
    while (done3 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("d3_latency2", n, 12);
    check_val("d3_bcd_99", bcd3, 12'h099);
    check_val("d3_ovf_clr", ovf3, 0);
    check_val("d3_blank_99", blank3, BLK_EN ? 3'b100 : 3'b000);
    tick();

    // reset asserted mid-conversion aborts and clears outputs
    bin_in = 11'd1999;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check_val("abort_state", {busy, done, overflow, bcd_out, blank}, 0);
    repeat (3) tick();
    rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check_val("abort_no_done", pulses, 0);
    check_val("abort_idle", {busy, bcd_out}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly downstream of the summation datapath. It takes the 11-bit accumulator result and produces packed BCD digits for the 7-segment digit decoders.
- Replaces divide/modulo logic with a multi-cycle handshake converter: one result bit is consumed per clock.

Parameters:
BIN_W, 11, width of binary input (max sum 2016 fits in 11 bits)
DIGITS, 4, number of BCD digits produced (units first in LSBs)

Ports:
clk  input  1  system clock (divided clock domain of the consumer)
rst  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bin_in  input  BIN_W  binary value; captured on the accepting edge
busy  output  1  high from the accepting edge until the DONE cycle ends
done  output  1  single-cycle pulse when bcd_out is updated
bcd_out  output  4*DIGITS  packed BCD; digit i in bits [4i+3:4i]
overflow  output  1  set when bin_in >= 10^DIGITS; valid alongside done
blank  output  DIGITS  per-digit blanking mask (see Optional Feature)

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, done=0, overflow=0, bcd_out=0, blank=0; internal shift/BCD registers and bit counter cleared.
- Reset asserted mid-conversion aborts it immediately; no done pulse follows.
- State IDLE:
  - On an edge with start=1, capture bin_in into the shift register, clear the working BCD register, load the bit counter with BIN_W, and go to SHIFT.
  - busy rises after this edge.
- State SHIFT, one iteration per edge:
  - Every working digit >=5 gets +3 (all digits in parallel).
  - Then {bcd, shift} is shifted left one bit.
  - The bit shifted out of the top digit ORs into a sticky overflow bit.
  - The counter decrements.
  - On the edge where the counter goes 1->0, bcd_out and overflow are loaded from the post-shift value and the state goes to DONE.
- State DONE (exactly one cycle): done=1, busy=1. Next edge goes to IDLE, where busy=0 and done=0.
- Latency: the capture edge plus BIN_W shift edges. done is high in the cycle after the (BIN_W+1)-th edge counted from and including the capture edge. For BIN_W=11 that is 12 edges, so the next start can be accepted 13 edges after the previous one.
- start while busy (SHIFT or DONE) is ignored, not queued. A start held high in the IDLE cycle after DONE begins a new conversion.
- bcd_out/overflow hold their last value between conversions. They are NOT cleared at start, so the display does not flicker.
- Overflow case: bcd_out = bin_in mod 10^DIGITS. Cannot occur with defaults; reachable with DIGITS=3.
- bin_in changes after capture have no effect.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: blank is registered together with bcd_out. blank[i]=1 iff digit i and all higher digits are zero, for i>=1. blank[0] is always 0, so value 0 shows a single "0".
- Undefined: blank is tied to 0. Port list is unchanged.

Decomposition:
- Shared package sum_pkg: state encoding (IDLE, SHIFT, DONE), BCD digit width constant (4), add-3 threshold constant (5), default BIN_W/DIGITS.
- One natural sub-module, bcd_add3: combinational 4-bit correction cell (in>=5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- Reset then idle: rst low for 3 cycles mid-run -> busy=0, done=0, bcd_out=0x0000, overflow=0; after release, no done without start.
- bin_in=2016, start pulse -> done exactly 12 edges after capture edge, bcd_out=0x2016, overflow=0, busy high for 12 cycles.
- bin_in=0 then bin_in=2047 back-to-back, start held high continuously -> two conversions, second accepted the cycle after DONE, outputs 0x0000 then 0x2047.
- start re-pulsed and bin_in changed to 5 during SHIFT of value 1234 -> ignored; result 0x1234, single done pulse.
- DIGITS=3 build, bin_in=1275 -> bcd_out=0x275, overflow=1; next conversion of 99 -> 0x099, overflow=0.
- LEADING_ZERO_BLANK_EN defined, bin_in=7 -> blank=4'b1110; bin_in=0 -> blank=4'b1110; bin_in=105 -> blank=4'b1000; macro undefined -> blank=0 always.
